// File: rtl/ucode_test_monitor.sv
// Microcode test monitor: watches the execute/fetch stream against programmable
// pass/skip/fail/end tables, drives skip redirects and reports run outcome.
module ucode_test_monitor #(
    parameter int PC_W  = 12,
    parameter int NPASS = 16,
    parameter int NSKIP = 4,
    parameter int NFAIL = 3,
    parameter int CNT_W = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_sel,
    input  logic [5:0]           cfg_idx,
    input  logic [3*PC_W:0]      cfg_data,
    input  logic [CNT_W-1:0]     cfg_limit,
    input  logic                 ex_valid,
    input  logic [PC_W-1:0]      ex_pc,
    input  logic [112:1]         ex_op,
    input  logic [PC_W-1:0]      f_pc,
    output logic                 redirect,
    output logic [PC_W-1:0]      redirect_pc,
    output logic                 evt_valid,
    output logic [2:0]           evt_kind,
    output logic [5:0]           evt_idx,
    output logic [NPASS-1:0]     hit_mask,
    output logic [2:0]           state,
    output logic                 done,
    output logic [CNT_W-1:0]     cycles
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [2:0] EV_PASS = 3'd0;
    localparam logic [2:0] EV_SKIP = 3'd1;
    localparam logic [2:0] EV_FAIL = 3'd2;
    localparam logic [2:0] EV_END  = 3'd3;
    localparam logic [2:0] EV_INC  = 3'd4;
    localparam logic [2:0] EV_TMO  = 3'd5;

    state_t state_q, state_n;

    logic [NPASS-1:0]            pass_v;
    logic [NPASS-1:0][PC_W-1:0]  pass_a;
    logic [NSKIP-1:0]            skip_v;
    logic [NSKIP-1:0][PC_W-1:0]  skip_a, skip_b, skip_c;
    logic [NFAIL-1:0]            fail_v;
    logic [NFAIL-1:0][PC_W-1:0]  fail_a;
    logic                        end_v;
    logic [PC_W-1:0]             end_a;
    logic [CNT_W-1:0]            limit;

    logic [PC_W-1:0] cfg_a, cfg_b, cfg_c;
    assign cfg_a = cfg_data[PC_W:1];
    assign cfg_b = cfg_data[2*PC_W:PC_W+1];
    assign cfg_c = cfg_data[3*PC_W:2*PC_W+1];

    // Opcode fields used by the pass-label match (CONT with map 0).
    logic [3:0]      op_sqi;
    logic [1:0]      op_map;
    logic [PC_W-1:0] op_a;
    logic            unused_op;
    assign op_sqi    = ex_op[112:109];
    assign op_map    = ex_op[96:95];
    assign op_a      = PC_W'(ex_op[108:97]);
    assign unused_op = ^ex_op[94:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_v <= '0;
            pass_a <= '0;
            skip_v <= '0;
            skip_a <= '0;
            skip_b <= '0;
            skip_c <= '0;
            fail_v <= '0;
            fail_a <= '0;
            end_v  <= 1'b0;
            end_a  <= '0;
            limit  <= CNT_W'(100000);
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0: for (int i = 0; i < NPASS; i++)
                    if (cfg_idx == 6'(i)) begin
                        pass_v[i] <= cfg_data[0];
                        pass_a[i] <= cfg_a;
                    end
                2'd1: for (int i = 0; i < NSKIP; i++)
                    if (cfg_idx == 6'(i)) begin
                        skip_v[i] <= cfg_data[0];
                        skip_a[i] <= cfg_a;
                        skip_b[i] <= cfg_b;
                        skip_c[i] <= cfg_c;
                    end
                2'd2: for (int i = 0; i < NFAIL; i++)
                    if (cfg_idx == 6'(i)) begin
                        fail_v[i] <= cfg_data[0];
                        fail_a[i] <= cfg_a;
                    end
                default: begin
                    end_v <= cfg_data[0];
                    end_a <= cfg_a;
                    limit <= cfg_limit;
                end
            endcase
        end
    end

    // Table lookups; descending scans leave the lowest matching index.
    logic            fail_hit, skip_hit, pass_hit, end_hit, all_hit, tmo_hit;
    logic [5:0]      fail_idx, skip_idx, pass_idx;
    logic [PC_W-1:0] skip_pc;
    logic [NPASS-1:0] pass_sel;
    logic [CNT_W-1:0] lim_m1;

    assign lim_m1  = limit - CNT_W'(1);
    assign tmo_hit = (cycles == lim_m1);
    assign end_hit = end_v && (end_a == ex_pc);
    assign all_hit = ((pass_v & ~hit_mask) == '0);

    always_comb begin
        fail_hit = 1'b0;
        fail_idx = '0;
        for (int i = NFAIL-1; i >= 0; i--)
            if (fail_v[i] && fail_a[i] == ex_pc) begin
                fail_hit = 1'b1;
                fail_idx = 6'(i);
            end
        skip_hit = 1'b0;
        skip_idx = '0;
        skip_pc  = '0;
        for (int i = NSKIP-1; i >= 0; i--)
            if (skip_v[i] && skip_a[i] == ex_pc && skip_b[i] == f_pc) begin
                skip_hit = 1'b1;
                skip_idx = 6'(i);
                skip_pc  = skip_c[i];
            end
        pass_hit = 1'b0;
        pass_idx = '0;
        pass_sel = '0;
        if (op_sqi == 4'd14 && op_map == 2'd0)
            for (int i = NPASS-1; i >= 0; i--)
                if (pass_v[i] && pass_a[i] == op_a && !hit_mask[i]) begin
                    pass_hit    = 1'b1;
                    pass_idx    = 6'(i);
                    pass_sel    = '0;
                    pass_sel[i] = 1'b1;
                end
    end

    logic             evt_valid_n, redirect_n;
    logic [2:0]       evt_kind_n;
    logic [5:0]       evt_idx_n;
    logic [PC_W-1:0]  redirect_pc_n;
    logic [NPASS-1:0] hit_n;
    logic [CNT_W-1:0] cycles_n;

    always_comb begin
        state_n       = state_q;
        evt_valid_n   = 1'b0;
        evt_kind_n    = '0;
        evt_idx_n     = '0;
        redirect_n    = 1'b0;
        redirect_pc_n = '0;
        hit_n         = hit_mask;
        cycles_n      = cycles;
        case (state_q)
            S_RUN: begin
                // Counter parks at limit-1 so a timeout leaves cycles = limit-1.
                if (!tmo_hit && cycles != '1)
                    cycles_n = cycles + CNT_W'(1);
                if (ex_valid && fail_hit) begin
                    state_n     = S_FAIL;
                    evt_valid_n = 1'b1;
                    evt_kind_n  = EV_FAIL;
                    evt_idx_n   = fail_idx;
                end else if (ex_valid && end_hit) begin
                    state_n     = all_hit ? S_PASS : S_FAIL;
                    evt_valid_n = 1'b1;
                    evt_kind_n  = all_hit ? EV_END : EV_INC;
                end else if (tmo_hit) begin
                    state_n     = S_TIMEOUT;
                    evt_valid_n = 1'b1;
                    evt_kind_n  = EV_TMO;
                end else if (ex_valid && skip_hit && !redirect) begin
                    evt_valid_n   = 1'b1;
                    evt_kind_n    = EV_SKIP;
                    evt_idx_n     = skip_idx;
                    redirect_n    = 1'b1;
                    redirect_pc_n = skip_pc;
                end else if (ex_valid && pass_hit) begin
                    evt_valid_n = 1'b1;
                    evt_kind_n  = EV_PASS;
                    evt_idx_n   = pass_idx;
                    hit_n       = hit_mask | pass_sel;
                end
            end
            default: begin
                if (start) begin
                    state_n  = S_RUN;
                    hit_n    = '0;
                    cycles_n = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            evt_valid   <= 1'b0;
            evt_kind    <= '0;
            evt_idx     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            hit_mask    <= '0;
            cycles      <= '0;
        end else begin
            state_q     <= state_n;
            evt_valid   <= evt_valid_n;
            evt_kind    <= evt_kind_n;
            evt_idx     <= evt_idx_n;
            redirect    <= redirect_n;
            redirect_pc <= redirect_pc_n;
            hit_mask    <= hit_n;
            cycles      <= cycles_n;
        end
    end

    assign state = state_q;
    assign done  = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_ucode_test_monitor.sv
// Scenario bench for ucode_test_monitor: tasks push expected events into a
// queue, a negedge monitor pops and compares each event the DUT emits.
module tb_ucode_test_monitor;

    localparam int PC_W  = 12;
    localparam int NPASS = 16;
    localparam int NSKIP = 4;
    localparam int NFAIL = 3;
    localparam int CNT_W = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_sel = '0;
    logic [5:0]        cfg_idx = '0;
    logic [3*PC_W:0]   cfg_data = '0;
    logic [CNT_W-1:0]  cfg_limit = '0;
    logic              ex_valid = 1'b0;
    logic [PC_W-1:0]   ex_pc = '0;
    logic [112:1]      ex_op = '0;
    logic [PC_W-1:0]   f_pc = '0;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              evt_valid;
    logic [2:0]        evt_kind;
    logic [5:0]        evt_idx;
    logic [NPASS-1:0]  hit_mask;
    logic [2:0]        state;
    logic              done;
    logic [CNT_W-1:0]  cycles;

    ucode_test_monitor #(
        .PC_W(PC_W), .NPASS(NPASS), .NSKIP(NSKIP), .NFAIL(NFAIL), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_limit(cfg_limit),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op(ex_op), .f_pc(f_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .evt_valid(evt_valid), .evt_kind(evt_kind), .evt_idx(evt_idx),
        .hit_mask(hit_mask), .state(state), .done(done), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]      kind;
        logic [5:0]      idx;
        logic            rd;
        logic [PC_W-1:0] rpc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (evt_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected: got kind=%0d idx=%0d rd=%0b, expected no event",
                             evt_kind, evt_idx, redirect);
                end else begin
                    mon_e = sbq.pop_front();
                    if ({evt_kind, evt_idx, redirect, redirect_pc} !==
                        {mon_e.kind, mon_e.idx, mon_e.rd, mon_e.rpc}) begin
                        errors++;
                        $display("FAIL evt_match: got kind=%0d idx=%0d rd=%0b rpc=%0d, expected kind=%0d idx=%0d rd=%0b rpc=%0d",
                                 evt_kind, evt_idx, redirect, redirect_pc,
                                 mon_e.kind, mon_e.idx, mon_e.rd, mon_e.rpc);
                    end
                end
            end else if (redirect) begin
                checks++;
                errors++;
                $display("FAIL redirect_alone: got redirect=1 without event, expected 0");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] k, input logic [5:0] i,
                            input logic rd, input logic [PC_W-1:0] rpc);
        exp_t e;
        e.kind = k;
        e.idx  = i;
        e.rd   = rd;
        e.rpc  = rpc;
        sbq.push_back(e);
    endtask

    function automatic logic [112:1] mk_op(input logic [3:0] sqi, input logic [1:0] map,
                                           input logic [11:0] a);
        logic [112:1] op;
        op = '0;
        op[112:109] = sqi;
        op[108:97]  = a;
        op[96:95]   = map;
        return op;
    endfunction

    task automatic drive(input logic v, input logic [PC_W-1:0] pc,
                         input logic [PC_W-1:0] fpc, input logic [112:1] op);
        ex_valid = v;
        ex_pc    = pc;
        f_pc     = fpc;
        ex_op    = op;
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [5:0] idx, input logic v,
                       input logic [PC_W-1:0] a, input logic [PC_W-1:0] b,
                       input logic [PC_W-1:0] c, input logic [CNT_W-1:0] lim);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_idx   = idx;
        cfg_data  = {c, b, a, v};
        cfg_limit = lim;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        cfg_we = 1'b0;
        drive(1'b0, '0, '0, '0);
        sbq.delete();
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got state=%0d done=%0b, expected 0 0", state, done);
        end
        checks++;
        if ({evt_valid, evt_kind, evt_idx, redirect, redirect_pc, hit_mask, cycles} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%0b k=%0d i=%0d rd=%0b rpc=%0d hm=%h cyc=%0d, expected all 0",
                     evt_valid, evt_kind, evt_idx, redirect, redirect_pc, hit_mask, cycles);
        end
        do_reset();
    endtask

    task automatic test_pass_end();
        do_reset();
        cfg(2'd0, 6'd0, 1'b1, 12'd12, '0, '0, '0);
        cfg(2'd0, 6'd1, 1'b1, 12'd28, '0, '0, '0);
        cfg(2'd0, 6'd2, 1'b0, 12'd50, '0, '0, '0);
        cfg(2'd3, 6'd0, 1'b1, 12'd1563, '0, '0, 20'd100000);
        pulse_start();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL pass_run_state: got %0d, expected 1", state);
        end
        push_exp(3'd0, 6'd0, 1'b0, '0);
        drive(1'b1, 12'd100, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        drive(1'b1, 12'd101, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        drive(1'b1, 12'd102, 12'd0, mk_op(4'd14, 2'd1, 12'd28));
        step();
        push_exp(3'd0, 6'd1, 1'b0, '0);
        drive(1'b1, 12'd103, 12'd0, mk_op(4'd14, 2'd0, 12'd28));
        step();
        push_exp(3'd3, 6'd0, 1'b0, '0);
        drive(1'b1, 12'd1563, 12'd0, '0);
        step();
        checks++;
        if (state !== 3'd2 || done !== 1'b1 || hit_mask !== 16'h0003) begin
            errors++;
            $display("FAIL pass_end: got state=%0d done=%0b hm=%h, expected 2 1 0003", state, done, hit_mask);
        end
        step();
        step();
        checks++;
        if (state !== 3'd2 || sbq.size() != 0) begin
            errors++;
            $display("FAIL pass_hold: got state=%0d pending=%0d, expected 2 0", state, sbq.size());
        end
        drive(1'b0, '0, '0, '0);
    endtask

    task automatic test_skip();
        do_reset();
        cfg(2'd1, 6'd0, 1'b1, 12'd0, 12'd1, 12'd8, '0);
        cfg(2'd1, 6'd1, 1'b1, 12'd0, 12'd1, 12'd9, '0);
        pulse_start();
        push_exp(3'd1, 6'd0, 1'b1, 12'd8);
        drive(1'b1, 12'd0, 12'd1, '0);
        step();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 12'd8) begin
            errors++;
            $display("FAIL skip_first: got rd=%0b rpc=%0d, expected 1 8", redirect, redirect_pc);
        end
        step();
        checks++;
        if (redirect !== 1'b0 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL skip_suppress: got rd=%0b ev=%0b, expected 0 0", redirect, evt_valid);
        end
        push_exp(3'd1, 6'd0, 1'b1, 12'd8);
        step();
        checks++;
        if (redirect !== 1'b1) begin
            errors++;
            $display("FAIL skip_again: got rd=%0b, expected 1", redirect);
        end
        drive(1'b1, 12'd0, 12'd2, '0);
        step();
        checks++;
        if (redirect !== 1'b0) begin
            errors++;
            $display("FAIL skip_fpc_miss: got rd=%0b, expected 0", redirect);
        end
        drive(1'b0, '0, '0, '0);
        step();
        checks++;
        if (sbq.size() != 0 || state !== 3'd1) begin
            errors++;
            $display("FAIL skip_drain: got pending=%0d state=%0d, expected 0 1", sbq.size(), state);
        end
    endtask

    task automatic test_fail_priority();
        do_reset();
        cfg(2'd0, 6'd0, 1'b1, 12'd12, '0, '0, '0);
        cfg(2'd2, 6'd2, 1'b1, 12'd1665, '0, '0, '0);
        cfg(2'd3, 6'd0, 1'b1, 12'd1665, '0, '0, 20'd100000);
        pulse_start();
        push_exp(3'd2, 6'd2, 1'b0, '0);
        drive(1'b1, 12'd1665, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        checks++;
        if (state !== 3'd3 || hit_mask !== 16'h0000 || evt_kind !== 3'd2) begin
            errors++;
            $display("FAIL fail_prio: got state=%0d hm=%h kind=%0d, expected 3 0000 2", state, hit_mask, evt_kind);
        end
        step();
        step();
        checks++;
        if (state !== 3'd3 || sbq.size() != 0) begin
            errors++;
            $display("FAIL fail_hold: got state=%0d pending=%0d, expected 3 0", state, sbq.size());
        end
        drive(1'b0, '0, '0, '0);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        cfg(2'd3, 6'd0, 1'b0, '0, '0, '0, 20'd50);
        pulse_start();
        push_exp(3'd5, 6'd0, 1'b0, '0);
        n = 0;
        while (state !== 3'd4 && n < 60) begin
            step();
            n++;
            if (n == 10) begin
                checks++;
                if (cycles !== 20'd10) begin
                    errors++;
                    $display("FAIL tmo_count: got %0d, expected 10", cycles);
                end
            end
        end
        checks++;
        if (n != 50 || cycles !== 20'd49 || done !== 1'b1) begin
            errors++;
            $display("FAIL tmo_end: got steps=%0d cycles=%0d done=%0b, expected 50 49 1", n, cycles, done);
        end
        step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL tmo_event: got pending=%0d, expected 0", sbq.size());
        end
    endtask

    task automatic test_restart();
        pulse_start();
        checks++;
        if (state !== 3'd1 || cycles !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart: got state=%0d cycles=%0d done=%0b, expected 1 0 0", state, cycles, done);
        end
        repeat (3) step();
        pulse_start();
        checks++;
        if (state !== 3'd1 || cycles !== 20'd4) begin
            errors++;
            $display("FAIL start_in_run: got state=%0d cycles=%0d, expected 1 4", state, cycles);
        end
    endtask

    task automatic test_incomplete();
        do_reset();
        cfg(2'd0, 6'd0, 1'b1, 12'd12, '0, '0, '0);
        cfg(2'd0, 6'd1, 1'b1, 12'd28, '0, '0, '0);
        cfg(2'd2, 6'd3, 1'b1, 12'd1563, '0, '0, '0);
        cfg(2'd3, 6'd0, 1'b1, 12'd1563, '0, '0, 20'd100000);
        pulse_start();
        push_exp(3'd0, 6'd0, 1'b0, '0);
        drive(1'b1, 12'd7, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        push_exp(3'd4, 6'd0, 1'b0, '0);
        drive(1'b1, 12'd1563, 12'd0, '0);
        step();
        checks++;
        if (state !== 3'd3 || evt_kind !== 3'd4 || hit_mask !== 16'h0001) begin
            errors++;
            $display("FAIL incomplete: got state=%0d kind=%0d hm=%h, expected 3 4 0001", state, evt_kind, hit_mask);
        end
        drive(1'b0, '0, '0, '0);
        step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL incomplete_drain: got pending=%0d, expected 0", sbq.size());
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        do_reset();
        cfg(2'd0, 6'd0, 1'b1, 12'd12, '0, '0, '0);
        cfg(2'd2, 6'd0, 1'b1, 12'd1665, '0, '0, '0);
        cfg(2'd3, 6'd0, 1'b1, 12'd1563, '0, '0, 20'd100000);
        pulse_start();
        push_exp(3'd0, 6'd0, 1'b0, '0);
        drive(1'b1, 12'd5, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        drive(1'b0, '0, '0, '0);
        step();
        reset = 1'b1;
        #2;
        checks++;
        if ({state, done, evt_valid, redirect, hit_mask, cycles} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got state=%0d done=%0b ev=%0b rd=%0b hm=%h cyc=%0d, expected all 0",
                     state, done, evt_valid, redirect, hit_mask, cycles);
        end
        step();
        reset = 1'b0;
        step();
        pulse_start();
        drive(1'b1, 12'd1665, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        drive(1'b1, 12'd1563, 12'd0, mk_op(4'd14, 2'd0, 12'd12));
        step();
        drive(1'b1, 12'd0, 12'd0, '0);
        step();
        checks++;
        if (state !== 3'd1 || hit_mask !== '0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL cfg_cleared: got state=%0d hm=%h pending=%0d, expected 1 0000 0", state, hit_mask, sbq.size());
        end
        cfg(2'd3, 6'd0, 1'b0, '0, '0, '0, 20'd20);
        push_exp(3'd5, 6'd0, 1'b0, '0);
        n = 0;
        while (state !== 3'd4 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (state !== 3'd4 || cycles !== 20'd19) begin
            errors++;
            $display("FAIL midrun_timeout: got state=%0d cycles=%0d, expected 4 19", state, cycles);
        end
        drive(1'b0, '0, '0, '0);
        step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL midrun_drain: got pending=%0d, expected 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_pass_end();
        test_skip();
        test_fail_priority();
        test_timeout();
        test_restart();
        test_incomplete();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1);
    end

endmodule
